// File: rtl/hash_pkg.sv
// Shared widths, scheme encoding and the last-beat byte-count helper for the SHA-2 front end.
// Optional feature macro (consumed in message_packer_lane): MESSAGE_PACKER_SWAP_EN.
package hash_pkg;

  localparam int unsigned BLOCK_W         = 512;
  localparam int unsigned WORD_W          = 32;
  localparam int unsigned SIZE_W          = 64;
  localparam int unsigned WORDS_PER_BLOCK = 16;
  localparam int unsigned WCNT_W          = 4;
  localparam int unsigned BYTES_W         = 3;
  localparam int unsigned SCHEME_W        = 2;
  localparam int unsigned WORD_BYTES      = WORD_W / 8;

  typedef enum logic [SCHEME_W-1:0] {
    SCHEME_SHA224 = 2'd0,
    SCHEME_SHA256 = 2'd1,
    SCHEME_SHA384 = 2'd2,
    SCHEME_SHA512 = 2'd3
  } hash_scheme_t;

  // Bytes actually kept from a beat: full word unless last; a zero count only
  // means "empty message" on the first beat, otherwise it is treated as full.
  function automatic logic [BYTES_W-1:0] eff_bytes(
    input logic [BYTES_W-1:0] bytes,
    input logic               last,
    input logic               in_msg
  );
    logic [BYTES_W-1:0] full;
    full = BYTES_W'(WORD_BYTES);
    if (!last)                  eff_bytes = full;
    else if (bytes == '0)       eff_bytes = in_msg ? full : '0;
    else if (bytes > full)      eff_bytes = full;
    else                        eff_bytes = bytes;
  endfunction

endpackage

// File: rtl/message_packer_lane.sv
// Per-word byte ordering and partial-beat masking (keeps the upper n bytes).
// MESSAGE_PACKER_SWAP_EN: byte-reverse each word first, for little-endian sources.
module message_packer_lane
  import hash_pkg::*;
(
  input  logic [WORD_W-1:0]  word_in,
  input  logic [BYTES_W-1:0] n_bytes,
  output logic [WORD_W-1:0]  word_out_c
);

  logic [WORD_W-1:0] w_word;

`ifdef MESSAGE_PACKER_SWAP_EN
  assign w_word = {word_in[7:0], word_in[15:8], word_in[23:16], word_in[31:24]};
`else
  assign w_word = word_in;
`endif

  // Keep the first n stream bytes (MSB first), zero the rest.
  always_comb begin
    word_out_c = '0;
    for (int i = 0; i < int'(WORD_BYTES); i++) begin
      if (BYTES_W'(i) < n_bytes) begin
        word_out_c[WORD_W-1-8*i -: 8] = w_word[WORD_W-1-8*i -: 8];
      end
    end
  end

endmodule

// File: rtl/message_packer.sv
// Packs a last-terminated stream of 32-bit words into 512-bit big-endian blocks
// and issues one cfg beat (bit length + scheme) per message.
// Optional feature macro: MESSAGE_PACKER_SWAP_EN (little-endian source words).
module message_packer
  import hash_pkg::*;
(
  input  logic                clk,
  input  logic                nrst,
  input  logic [WORD_W-1:0]   word_in,
  input  logic [BYTES_W-1:0]  word_in_bytes,
  input  logic                word_in_last,
  input  logic                word_in_valid,
  output logic                word_in_ready,
  input  logic [SCHEME_W-1:0] scheme_sel,
  output logic [BLOCK_W-1:0]  data_out,
  output logic                data_out_last,
  output logic                data_out_valid,
  input  logic                data_out_ready,
  output logic [SIZE_W-1:0]   cfg_size,
  output logic [SCHEME_W-1:0] cfg_scheme,
  output logic                cfg_last,
  output logic                cfg_valid,
  input  logic                cfg_ready
);

  // State
  logic [BLOCK_W-1:0] r_acc;
  logic               r_acc_full;
  logic               r_acc_last;
  logic [WCNT_W-1:0]  r_wcnt;
  logic [SIZE_W-1:0]  r_bitcnt;
  logic               r_in_msg;
  hash_scheme_t       r_scheme;
  logic [BLOCK_W-1:0] r_out_data;
  logic               r_out_last;
  logic               r_out_valid;
  logic [SIZE_W-1:0]  r_cfg_size;
  hash_scheme_t       r_cfg_scheme;
  logic               r_cfg_valid;
  logic               r_ready;

  // Next-state
  logic [BLOCK_W-1:0] w_nxt_acc;
  logic               w_nxt_acc_full;
  logic               w_nxt_acc_last;
  logic [WCNT_W-1:0]  w_nxt_wcnt;
  logic [SIZE_W-1:0]  w_nxt_bitcnt;
  logic               w_nxt_in_msg;
  hash_scheme_t       w_nxt_scheme;
  logic [BLOCK_W-1:0] w_nxt_out_data;
  logic               w_nxt_out_last;
  logic               w_nxt_out_valid;
  logic [SIZE_W-1:0]  w_nxt_cfg_size;
  hash_scheme_t       w_nxt_cfg_scheme;
  logic               w_nxt_cfg_valid;
  logic               w_nxt_ready;

  // Datapath helpers
  logic [BYTES_W-1:0] w_eff;
  logic [WORD_W-1:0]  w_lane;
  logic               w_accept;
  logic               w_out_free;
  logic               w_complete;
  logic [SIZE_W-1:0]  w_bit_sum;
  hash_scheme_t       w_msg_scheme;
  logic [BLOCK_W-1:0] w_block;
  int unsigned        w_lane_lsb;

  assign w_eff = eff_bytes(word_in_bytes, word_in_last, r_in_msg);

  message_packer_lane u_lane (
    .word_in    (word_in),
    .n_bytes    (w_eff),
    .word_out_c (w_lane)
  );

  assign w_accept     = word_in_valid && r_ready;
  assign w_out_free   = !r_out_valid || data_out_ready;
  assign w_complete   = word_in_last || (r_wcnt == WCNT_W'(WORDS_PER_BLOCK - 1));
  assign w_bit_sum    = r_bitcnt + (SIZE_W'(w_eff) << 3);
  assign w_msg_scheme = r_in_msg ? r_scheme : hash_scheme_t'(scheme_sel);
  assign w_lane_lsb   = BLOCK_W - WORD_W * (32'(r_wcnt) + 32'd1);

  // Accumulator with the current beat merged in; lane 0 starts a fresh block.
  always_comb begin
    w_block = (r_wcnt == '0) ? '0 : r_acc;
    w_block[w_lane_lsb +: WORD_W] = w_lane;
  end

  // Next-state: output/cfg handshakes, parked-block transfer, beat acceptance.
  always_comb begin
    w_nxt_acc        = r_acc;
    w_nxt_acc_full   = r_acc_full;
    w_nxt_acc_last   = r_acc_last;
    w_nxt_wcnt       = r_wcnt;
    w_nxt_bitcnt     = r_bitcnt;
    w_nxt_in_msg     = r_in_msg;
    w_nxt_scheme     = r_scheme;
    w_nxt_out_data   = r_out_data;
    w_nxt_out_last   = r_out_last;
    w_nxt_out_valid  = r_out_valid;
    w_nxt_cfg_size   = r_cfg_size;
    w_nxt_cfg_scheme = r_cfg_scheme;
    w_nxt_cfg_valid  = r_cfg_valid;

    if (r_cfg_valid && cfg_ready) w_nxt_cfg_valid = 1'b0;
    if (r_out_valid && data_out_ready) w_nxt_out_valid = 1'b0;

    if (r_acc_full) begin
      // Parked block moves out as soon as the output register frees up.
      if (w_out_free) begin
        w_nxt_out_data  = r_acc;
        w_nxt_out_last  = r_acc_last;
        w_nxt_out_valid = 1'b1;
        w_nxt_acc_full  = 1'b0;
        if (r_acc_last) begin
          w_nxt_cfg_size   = r_bitcnt;
          w_nxt_cfg_scheme = r_scheme;
          w_nxt_cfg_valid  = 1'b1;
          w_nxt_bitcnt     = '0;
        end
      end
    end else if (w_accept) begin
      w_nxt_wcnt   = word_in_last ? '0 : WCNT_W'(r_wcnt + WCNT_W'(1));
      w_nxt_in_msg = !word_in_last;
      w_nxt_scheme = w_msg_scheme;
      w_nxt_bitcnt = w_bit_sum;
      w_nxt_acc    = w_block;
      if (w_complete) begin
        if (w_out_free) begin
          // Completed block goes straight out: no bubble between blocks.
          w_nxt_out_data  = w_block;
          w_nxt_out_last  = word_in_last;
          w_nxt_out_valid = 1'b1;
          if (word_in_last) begin
            w_nxt_cfg_size   = w_bit_sum;
            w_nxt_cfg_scheme = w_msg_scheme;
            w_nxt_cfg_valid  = 1'b1;
            w_nxt_bitcnt     = '0;
          end
        end else begin
          w_nxt_acc_full = 1'b1;
          w_nxt_acc_last = word_in_last;
        end
      end
    end

    w_nxt_ready = !w_nxt_acc_full && !w_nxt_cfg_valid;
  end

  // State register; ready is held low throughout reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_acc        <= '0;
      r_acc_full   <= 1'b0;
      r_acc_last   <= 1'b0;
      r_wcnt       <= '0;
      r_bitcnt     <= '0;
      r_in_msg     <= 1'b0;
      r_scheme     <= SCHEME_SHA224;
      r_out_data   <= '0;
      r_out_last   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_cfg_size   <= '0;
      r_cfg_scheme <= SCHEME_SHA224;
      r_cfg_valid  <= 1'b0;
      r_ready      <= 1'b0;
    end else begin
      r_acc        <= w_nxt_acc;
      r_acc_full   <= w_nxt_acc_full;
      r_acc_last   <= w_nxt_acc_last;
      r_wcnt       <= w_nxt_wcnt;
      r_bitcnt     <= w_nxt_bitcnt;
      r_in_msg     <= w_nxt_in_msg;
      r_scheme     <= w_nxt_scheme;
      r_out_data   <= w_nxt_out_data;
      r_out_last   <= w_nxt_out_last;
      r_out_valid  <= w_nxt_out_valid;
      r_cfg_size   <= w_nxt_cfg_size;
      r_cfg_scheme <= w_nxt_cfg_scheme;
      r_cfg_valid  <= w_nxt_cfg_valid;
      r_ready      <= w_nxt_ready;
    end
  end

  assign word_in_ready  = r_ready;
  assign data_out       = r_out_data;
  assign data_out_last  = r_out_last;
  assign data_out_valid = r_out_valid;
  assign cfg_size       = r_cfg_size;
  assign cfg_scheme     = r_cfg_scheme;
  assign cfg_valid      = r_cfg_valid;
  assign cfg_last       = 1'b1;

endmodule

// File: tb/tb_message_packer.sv
// Scoreboard bench for message_packer: directed messages push expected blocks/cfg,
// negedge monitors pop and compare on each handshake.
module tb_message_packer;
  import hash_pkg::*;

  logic         clk = 1'b0;
  logic         nrst;
  logic [31:0]  word_in;
  logic [2:0]   word_in_bytes;
  logic         word_in_last;
  logic         word_in_valid;
  logic         word_in_ready;
  logic [1:0]   scheme_sel;
  logic [511:0] data_out;
  logic         data_out_last;
  logic         data_out_valid;
  logic         data_out_ready;
  logic [63:0]  cfg_size;
  logic [1:0]   cfg_scheme;
  logic         cfg_last;
  logic         cfg_valid;
  logic         cfg_ready;

  message_packer dut (
    .clk            (clk),
    .nrst           (nrst),
    .word_in        (word_in),
    .word_in_bytes  (word_in_bytes),
    .word_in_last   (word_in_last),
    .word_in_valid  (word_in_valid),
    .word_in_ready  (word_in_ready),
    .scheme_sel     (scheme_sel),
    .data_out       (data_out),
    .data_out_last  (data_out_last),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .cfg_size       (cfg_size),
    .cfg_scheme     (cfg_scheme),
    .cfg_last       (cfg_last),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [511:0] data; logic last; } blk_t;
  typedef struct packed { logic [63:0] size; logic [1:0] scheme; } cfg_t;

  blk_t exp_blk[$];
  cfg_t exp_cfg[$];
  int   blk_cycles[$];
  int   total = 0;
  int   bad = 0;
  int   cycle = 0;
  int   words_accepted = 0;
  logic tb_in_msg = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] put_lane(input logic [511:0] blk, input int lane, input logic [31:0] w);
    logic [511:0] b;
    b = blk;
    b[511-32*lane -: 32] = w;
    return b;
  endfunction

  // Block monitor: compare on handshake, enforce hold stability, cfg alongside last block.
  logic [511:0] prev_data;
  logic         prev_last, prev_valid = 1'b0, prev_ready = 1'b0;
  always @(negedge clk) begin
    blk_t e;
    cycle++;
    if (!nrst) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        check("blk_hold_valid", 512'(data_out_valid), 512'd1);
        check("blk_hold_data", data_out, prev_data);
        check("blk_hold_last", 512'(data_out_last), 512'(prev_last));
      end
      if (data_out_valid && (!prev_valid || prev_ready) && data_out_last)
        check("cfg_with_last_blk", 512'(cfg_valid), 512'd1);
      if (data_out_valid && data_out_ready) begin
        check("blk_expected", 512'(exp_blk.size() != 0), 512'd1);
        if (exp_blk.size() != 0) begin
          e = exp_blk.pop_front();
          check("blk_data", data_out, e.data);
          check("blk_last", 512'(data_out_last), 512'(e.last));
        end
        blk_cycles.push_back(cycle);
      end
      prev_valid = data_out_valid;
      prev_ready = data_out_ready;
      prev_data  = data_out;
      prev_last  = data_out_last;
    end
  end

  // Cfg monitor.
  logic [63:0] prev_size;
  logic [1:0]  prev_scheme;
  logic        prev_cvalid = 1'b0, prev_cready = 1'b0;
  always @(negedge clk) begin
    cfg_t e;
    if (!nrst) begin
      prev_cvalid = 1'b0;
    end else begin
      if (prev_cvalid && !prev_cready) begin
        check("cfg_hold_valid", 512'(cfg_valid), 512'd1);
        check("cfg_hold_size", 512'(cfg_size), 512'(prev_size));
        check("cfg_hold_scheme", 512'(cfg_scheme), 512'(prev_scheme));
      end
      if (cfg_valid && cfg_ready) begin
        check("cfg_expected", 512'(exp_cfg.size() != 0), 512'd1);
        if (exp_cfg.size() != 0) begin
          e = exp_cfg.pop_front();
          check("cfg_size", 512'(cfg_size), 512'(e.size));
          check("cfg_scheme", 512'(cfg_scheme), 512'(e.scheme));
          check("cfg_last", 512'(cfg_last), 512'd1);
        end
      end
      prev_cvalid = cfg_valid;
      prev_cready = cfg_ready;
      prev_size   = cfg_size;
      prev_scheme = cfg_scheme;
    end
  end

  task automatic send(input logic [31:0] w, input logic [2:0] b, input logic l, input logic [1:0] s);
    logic accepted;
    assert (!(l && b == 3'd0 && tb_in_msg)) else $error("protocol: zero-byte last beat inside a message");
    word_in       = w;
    word_in_bytes = b;
    word_in_last  = l;
    scheme_sel    = s;
    word_in_valid = 1'b1;
    accepted      = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (word_in_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    check("send_accepted", 512'(accepted), 512'd1);
    if (accepted) begin
      @(posedge clk);
      #1;
      words_accepted++;
      tb_in_msg = !l;
    end
    word_in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 300; t++) begin
      if (exp_blk.size() == 0 && exp_cfg.size() == 0) break;
      @(posedge clk);
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain_blk_queue", 512'(exp_blk.size()), 512'd0);
    check("drain_cfg_queue", 512'(exp_cfg.size()), 512'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, data_out, 512'd0);
    check({tag, "_last"}, 512'(data_out_last), 512'd0);
    check({tag, "_valid"}, 512'(data_out_valid), 512'd0);
    check({tag, "_cfg_size"}, 512'(cfg_size), 512'd0);
    check({tag, "_cfg_scheme"}, 512'(cfg_scheme), 512'd0);
    check({tag, "_cfg_valid"}, 512'(cfg_valid), 512'd0);
    check({tag, "_cfg_last"}, 512'(cfg_last), 512'd1);
    check({tag, "_in_ready"}, 512'(word_in_ready), 512'd0);
  endtask

  task automatic abc_msg();
    exp_blk.push_back('{data: {32'h61626300, 480'd0}, last: 1'b1});
    exp_cfg.push_back('{size: 64'd24, scheme: 2'd1});
    send(32'h61626300, 3'd3, 1'b1, 2'd1);
    drain();
  endtask

  initial begin
    logic [511:0] b0, b1, b2;
    nrst = 1'b0;
    word_in = '0; word_in_bytes = '0; word_in_last = 1'b0; word_in_valid = 1'b0;
    scheme_sel = '0; data_out_ready = 1'b1; cfg_ready = 1'b1;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1; nrst = 1'b1;
    @(posedge clk); #1;

    // "abc"
    abc_msg();

    // 16 words, one full last block
    b0 = '0;
    for (int k = 0; k < 16; k++) b0 = put_lane(b0, k, 32'(k));
    exp_blk.push_back('{data: b0, last: 1'b1});
    exp_cfg.push_back('{size: 64'd512, scheme: 2'd2});
    for (int k = 0; k < 16; k++) send(32'(k), 3'd4, (k == 15), 2'd2);
    drain();

    // 17 words, back-to-back blocks
    b0 = '0;
    for (int k = 0; k < 16; k++) b0 = put_lane(b0, k, 32'hA000_0000 + 32'(k));
    exp_blk.push_back('{data: b0, last: 1'b0});
    exp_blk.push_back('{data: {32'hDEADBEEF, 480'd0}, last: 1'b1});
    exp_cfg.push_back('{size: 64'd544, scheme: 2'd3});
    blk_cycles.delete();
    for (int k = 0; k < 16; k++) send(32'hA000_0000 + 32'(k), 3'd4, 1'b0, 2'd3);
    send(32'hDEADBEEF, 3'd4, 1'b1, 2'd3);
    drain();
    check("blk_count_17", 512'(blk_cycles.size()), 512'd2);
    if (blk_cycles.size() == 2)
      check("no_bubble_17", 512'(blk_cycles[1] - blk_cycles[0]), 512'd1);

    // Empty message, cfg held off: next message must stall
    cfg_ready = 1'b0;
    exp_blk.push_back('{data: 512'd0, last: 1'b1});
    exp_cfg.push_back('{size: 64'd0, scheme: 2'd2});
    send(32'hFFFF_FFFF, 3'd0, 1'b1, 2'd2);
    repeat (4) @(posedge clk);
    #1;
    check("cfg_pending_valid", 512'(cfg_valid), 512'd1);
    check("cfg_pending_stall", 512'(word_in_ready), 512'd0);
    cfg_ready = 1'b1;
    drain();
    check("ready_after_cfg", 512'(word_in_ready), 512'd1);

    // 40 words with data_out_ready low for 40 cycles
    b0 = '0; b1 = '0; b2 = '0;
    for (int k = 0; k < 16; k++) b0 = put_lane(b0, k, 32'h1000_0000 + 32'(k));
    for (int k = 0; k < 16; k++) b1 = put_lane(b1, k, 32'h1000_0010 + 32'(k));
    for (int k = 0; k < 8; k++)  b2 = put_lane(b2, k, 32'h1000_0020 + 32'(k));
    exp_blk.push_back('{data: b0, last: 1'b0});
    exp_blk.push_back('{data: b1, last: 1'b0});
    exp_blk.push_back('{data: b2, last: 1'b1});
    exp_cfg.push_back('{size: 64'd1280, scheme: 2'd0});
    words_accepted = 0;
    data_out_ready = 1'b0;
    fork
      begin
        repeat (40) @(posedge clk);
        #1;
        check("hold_in_ready_low", 512'(word_in_ready), 512'd0);
        check("hold_words_taken", 512'(words_accepted), 512'd32);
        data_out_ready = 1'b1;
      end
      begin
        for (int k = 0; k < 40; k++) send(32'h1000_0000 + 32'(k), 3'd4, (k == 39), 2'd0);
      end
    join
    drain();

    // Reset mid-message, then "abc" again
    for (int k = 0; k < 5; k++) send(32'h5555_0000 + 32'(k), 3'd4, 1'b0, 2'd3);
    nrst = 1'b0;
    #2;
    check_reset_outputs("midreset");
    tb_in_msg = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;
    abc_msg();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/message_packer.md
# message_packer

Upstream feeder for the SHA-2 message builder. Accepts a message as a stream of 32-bit words with valid/ready handshake, packs them big-endian into 512-bit blocks, and drives the builder's data port (`data_out*`) and configuration port (`cfg_*`). It counts message length in bits so the builder receives the exact `cfg_size` it needs for padding. One message is in flight per `last`-terminated stream.

## Interface
- No parameters. All widths come from `hash_pkg`.
- `clk`  in  1  system clock, all state on rising edge
- `nrst`  in  1  asynchronous active-low reset
- `word_in`  in  32  message word; the first stream byte is `[31:24]`
- `word_in_bytes`  in  3  valid bytes in the last beat, 0..4; ignored (taken as 4) when `word_in_last`=0
- `word_in_last`  in  1  final beat of the message
- `word_in_valid`  in  1  source has a word
- `word_in_ready`  out  1  packer accepts a word this cycle
- `scheme_sel`  in  2  SHA-2 scheme; sampled on the first beat of each message
- `data_out`  out  512  packed block; word 0 sits in `[511:480]`
- `data_out_last`  out  1  block is the final block of the message
- `data_out_valid`, `data_out_ready`  out, in  1  block handshake
- `cfg_size`  out  64  message length in bits
- `cfg_scheme`  out  2  scheme latched for this message
- `cfg_last`  out  1  constant 1; one cfg beat per message
- `cfg_valid`, `cfg_ready`  out, in  1  cfg handshake

## Operation
- A word transfers when `word_in_valid` and `word_in_ready` are both 1 on a clock edge. It is written into accumulator lane `wcnt` (4-bit counter, lane 0 is MSW), and `wcnt` increments.
- On a last beat with n bytes, only the upper n bytes are kept and the lower 4-n bytes are zeroed. All unwritten lanes of the final block are zero.
- The bit counter adds 32 on each non-last beat and 8·n on the last beat. It is 64-bit and wraps modulo 2^64.
- The accumulator becomes full when `wcnt` wraps (16th word) or a last beat is accepted. When full, it moves to the output register if that register is empty or is being accepted in the same cycle. Otherwise it stays full.
- `word_in_ready` = !acc_full && !cfg_valid. The next message therefore stalls until the previous cfg beat is consumed.
- On an accepted last beat, `cfg_size`, `cfg_scheme` and `cfg_valid` are loaded. `cfg_valid` holds until `cfg_ready`. The bit counter and `wcnt` then clear.
- Zero-length message: a single beat with `word_in_last`=1 and `word_in_bytes`=0 produces one all-zero block with last=1 and `cfg_size`=0.
- `word_in_bytes`=0 on any other last beat is a protocol violation. RTL treats it as 4, and the bench asserts it never occurs.
- Output data must not change while `data_out_valid`=1 and `data_out_ready`=0. The same rule applies to cfg.

## Timing
- Reset values: `data_out`=0, `data_out_last`=0, `data_out_valid`=0, `cfg_size`=0, `cfg_scheme`=0, `cfg_valid`=0, `cfg_last`=1, `word_in_ready`=0 while `nrst`=0. Internal state: `wcnt`=0, bit counter 0, acc_full=0.
- Reset asserted mid-message discards the partial block and the count. The first beat after reset packs into lane 0.
- `word_in_ready` is registered-state derived only; it has no combinational path from `word_in_valid`.
- Latency: `data_out_valid` rises 1 cycle after the completing beat, provided the output register is free. `cfg_valid` rises on the same edge as that message's last block.
- Sustained throughput is 1 word/cycle with `data_out_ready`=1, with no bubble between blocks.
- A transfer to the output register and an output accept in the same cycle keep `data_out_valid`=1 with the new block.

## Configuration
- `MESSAGE_PACKER_SWAP_EN` defined: each `word_in` is byte-reversed before lane write and masking, for little-endian sources. In this mode the valid bytes of a partial last beat are the lower n bytes of `word_in`.
- Not defined: words are used as presented; the first byte is `[31:24]`.

## Structure
- `hash_pkg` holds `BLOCK_W`=512, `WORD_W`=32, `SIZE_W`=64, `WORDS_PER_BLOCK`=16, and the `hash_scheme_t` enum (2-bit).
- One sub-module is natural: `message_packer_lane`, which applies the combinational byte swap and partial-beat mask to one 32-bit word. Everything else stays in `message_packer`.

## Test plan
- "abc": `word_in`=0x61626300, bytes=3, last → `data_out`[511:488]=0x616263, rest 0, last=1; `cfg_size`=24.
- 16 beats 0x00000000..0x0000000F, 16th last with bytes=4 → one block, lane k = k, last=1; `cfg_size`=512.
- 17 full beats, 17th last with value 0xDEADBEEF → block 1 last=0, block 2 `[511:480]`=0xDEADBEEF with rest 0 and last=1; `cfg_size`=544; no idle cycle between blocks.
- Empty message (bytes=0, last) → one zero block with last=1, `cfg_size`=0, `cfg_scheme`=`scheme_sel`.
- Hold `data_out_ready`=0 for 40 cycles during a 40-word message → `word_in_ready` drops once the accumulator is full; all blocks are later output unchanged and in order.
- Assert `nrst` after 5 words → all outputs return to reset values; a following "abc" message produces the same result as the first scenario.
